// File: rtl/ifetch_queue.sv
// Instruction fetch front end: owns the fetch PC, reads imem, and buffers
// {pc, inst} pairs in a small FIFO that decode drains via valid/ready.
module ifetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [31:0]              imem_addr,
  input  logic [31:0]              imem_inst,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_inst,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   fetch_pc;
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW:0]   count;
  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   inst_mem [DEPTH];

  logic full;
  logic pop;
  logic push;

  assign full      = (count == (AW+1)'(DEPTH));
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  // a full queue can still accept a new fetch when decode frees the head slot
  assign push      = !redirect_valid && (!full || pop);

  assign imem_addr = fetch_pc;
  assign occupancy = count;
  assign out_pc    = out_valid ? pc_mem[head]   : 32'h0;
  assign out_inst  = out_valid ? inst_mem[head] : 32'h0;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        tail     <= tail + AW'(1);
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (pop) begin
        head <= head + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // storage needs no reset: entries are only visible while counted
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      pc_mem[tail]   <= fetch_pc;
      inst_mem[tail] <= imem_inst;
    end
  end

endmodule
